// File: rtl/pfft_mul_arbiter.sv
// Round-robin share of one 43x36 multiplier; S1 operand reg, S2 result reg.
// Define PFFT_MUL_ARB_STATS_EN to add issue/stall counters.
module pfft_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 43,
  parameter int B_WIDTH  = 36,
  parameter int P_WIDTH  = 79,
  parameter int ID_WIDTH = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic [A_WIDTH-1:0]          mul_din0,
  output logic [B_WIDTH-1:0]          mul_din1,
  input  logic [P_WIDTH-1:0]          mul_dout,
  output logic                        rsp_valid,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic [P_WIDTH-1:0]          rsp_data,
  input  logic                        rsp_ready
`ifdef PFFT_MUL_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_issue_cnt,
  output logic [31:0]                 stat_stall_cnt
`endif
);

  localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_REQ - 1);

  logic                s1_valid;
  logic [A_WIDTH-1:0]  s1_a;
  logic [B_WIDTH-1:0]  s1_b;
  logic [ID_WIDTH-1:0] s1_id;
  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] win;
  logic [ID_WIDTH-1:0] cand;
  logic [NUM_REQ-1:0]  grant;
  logic [A_WIDTH-1:0]  a_sel;
  logic [B_WIDTH-1:0]  b_sel;
  logic                found;
  logic                s1_adv;
  logic                s2_adv;
  logic                xfer;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Search starts just past the last winner and wraps at NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    grant = '0;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST) ? '0 : cand + ID_WIDTH'(1);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (found) grant[win] = 1'b1;
  end

  assign req_ready = (ap_rst_n && s1_adv) ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*A_WIDTH +: A_WIDTH];
        b_sel = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  assign mul_din0 = s1_valid ? s1_a : '0;
  assign mul_din1 = s1_valid ? s1_b : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      ptr       <= LAST;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_a  <= a_sel;
          s1_b  <= b_sel;
          s1_id <= win;
          ptr   <= win;
        end
      end
      if (s2_adv) begin
        rsp_valid <= s1_valid;
        rsp_id    <= s1_id;
        rsp_data  <= mul_dout;
      end
    end
  end

`ifdef PFFT_MUL_ARB_STATS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (xfer && stat_issue_cnt != '1)
        stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if (rsp_valid && !rsp_ready && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pfft_mul_arbiter.sv
// Scoreboard bench for pfft_mul_arbiter; the bench models the shared
// multiplier and predicts every tagged product at handshake time.
module tb_pfft_mul_arbiter;

  localparam int N  = 4;
  localparam int AW = 43;
  localparam int BW = 36;
  localparam int PW = 79;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [PW-1:0]   rsp_data;
  logic            rsp_ready;
`ifdef PFFT_MUL_ARB_STATS_EN
  logic [31:0]     stat_issue_cnt;
  logic [31:0]     stat_stall_cnt;
`endif

  logic [AW-1:0] a_op [N];
  logic [BW-1:0] b_op [N];
  exp_t          sb [$];
  int            glog [$];
  logic [PW-1:0] dlog [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_rsp = 0;
  logic          one_shot = 1'b0;

  always #5 clk = ~clk;

  assign mul_dout = PW'(mul_din0) * PW'(mul_din1);

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = a_op[i];
      req_b[i*BW +: BW] = b_op[i];
    end
  end

  pfft_mul_arbiter dut (
    .ap_clk    (clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
`ifdef PFFT_MUL_ARB_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe(output logic [N-1:0] acc);
    exp_t e;
    acc = '0;
    chk("ready_onehot", 128'($onehot0(req_ready)), 128'(1));
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = IW'(i);
        e.data = PW'(a_op[i]) * PW'(b_op[i]);
        sb.push_back(e);
        glog.push_back(i);
        acc[i] = 1'b1;
      end
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      dlog.push_back(rsp_data);
      if (sb.size() == 0) begin
        chk("sb_empty", 128'(sb.size()), 128'(1));
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 128'(rsp_id), 128'(e.id));
        chk("rsp_data", 128'(rsp_data), 128'(e.data));
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    logic [N-1:0] acc;
    #1;
    observe(acc);
    @(negedge clk);
    if (one_shot) req_valid = req_valid & ~acc;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    sb.delete();
    glog.delete();
    dlog.delete();
    @(negedge clk);
    ap_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] prod_max;
    logic [IW-1:0] hid;
    logic [PW-1:0] hdata;
    int            r0;
`ifdef PFFT_MUL_ARB_STATS_EN
    logic [31:0]   base;
`endif
    ap_rst_n  = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_id", 128'(rsp_id), 128'(0));
    chk("rst_rsp_data", 128'(rsp_data), 128'(0));
    chk("rst_din0", 128'(mul_din0), 128'(0));
    @(negedge clk);
    ap_rst_n  = 1'b1;
    req_valid = '0;

    // single request with all-ones operands
    a_op[2]   = 43'h7FF_FFFF_FFFF;
    b_op[2]   = 36'hF_FFFF_FFFF;
    prod_max  = PW'(a_op[2]) * PW'(b_op[2]);
    one_shot  = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("single_grant", 128'(req_ready), 128'(4'b0100));
    tick();
    #1;
    chk("single_lat1", 128'(rsp_valid), 128'(0));
    tick();
    #1;
    chk("single_lat2", 128'(rsp_valid), 128'(1));
    chk("single_id", 128'(rsp_id), 128'(2));
    chk("single_data", 128'(rsp_data), 128'(prod_max));
    tick();
    one_shot = 1'b0;
    repeat (2) tick();

    // round robin, all requesters continuously valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_op[i] = AW'(i + 1);
      b_op[i] = BW'(3);
    end
    req_valid = '1;
    repeat (10) tick();
    for (int k = 0; k < 8; k++)
      chk("rr_grant", 128'(k < glog.size() ? glog[k] : 99), 128'(k % 4));
    for (int k = 0; k < 4; k++)
      chk("rr_data", 128'(k < dlog.size() ? dlog[k] : '1), 128'(3 * (k + 1)));

    // backpressure on a full pipeline
    do_reset();
    req_valid = '1;
    repeat (3) tick();
    rsp_ready = 1'b0;
    #1;
    hid   = rsp_id;
    hdata = rsp_data;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 128'(req_ready), 128'(0));
      chk("bp_valid", 128'(rsp_valid), 128'(1));
      chk("bp_id_hold", 128'(rsp_id), 128'(hid));
      chk("bp_data_hold", 128'(rsp_data), 128'(hdata));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
`ifdef PFFT_MUL_ARB_STATS_EN
    chk("bp_stall_cnt", 128'(stat_stall_cnt), 128'(5));
`endif
    r0 = n_rsp;
    repeat (6) tick();
    chk("bp_thruput", 128'(n_rsp - r0), 128'(6));

    // pointer wrap with sparse requesters
    do_reset();
    req_valid = 4'b1010;
    repeat (3) tick();
    chk("wrap_g0", 128'(glog.size() > 0 ? glog[0] : 99), 128'(1));
    chk("wrap_g1", 128'(glog.size() > 1 ? glog[1] : 99), 128'(3));
    chk("wrap_g2", 128'(glog.size() > 2 ? glog[2] : 99), 128'(1));

    // reset while S1 and S2 are both occupied
    do_reset();
    req_valid = '1;
    repeat (3) tick();
    rsp_ready = 1'b0;
    tick();
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(rsp_valid), 128'(0));
    chk("mid_rst_ready", 128'(req_ready), 128'(0));
    chk("mid_rst_din0", 128'(mul_din0), 128'(0));
    sb.delete();
    glog.delete();
    @(negedge clk);
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    ap_rst_n  = 1'b1;
    tick();
    chk("post_rst_grant", 128'(glog.size() > 0 ? glog[0] : 99), 128'(1));

    // idle
    req_valid = '0;
    repeat (3) tick();
`ifdef PFFT_MUL_ARB_STATS_EN
    base = stat_issue_cnt;
`endif
    repeat (4) begin
      #1;
      chk("idle_din0", 128'(mul_din0), 128'(0));
      chk("idle_din1", 128'(mul_din1), 128'(0));
      chk("idle_valid", 128'(rsp_valid), 128'(0));
      tick();
    end
`ifdef PFFT_MUL_ARB_STATS_EN
    chk("idle_issue_cnt", 128'(stat_issue_cnt), 128'(base));
`endif
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
